// File: rtl/timer_arbiter.sv
// timer_arbiter
//   Round-robin arbiter and sequencer for one shared down-counting interval
//   timer. Requesters raise req[i] and present interval[i*WIDTH +: WIDTH].
//   The winner is granted the timer, its interval is loaded into count, and
//   count decrements once per clock. On reaching zero a one-cycle done pulse
//   reports the owner and the timer is released for the next requester.
//
// Ports
//   clk      : single clock, all state updates on posedge
//   reset    : asynchronous active-low reset
//   req      : per-requester request level (bit i = requester i)
//   interval : packed per-requester intervals, sampled only at grant
//   grant    : one-hot timer owner, zero when idle
//   busy     : high while a grant is asserted
//   count    : remaining ticks of the current interval
//   done     : one-cycle completion pulse
//   done_id  : index of the requester that completed last (holds)
module timer_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] interval,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  done,
  output logic [IDW-1:0]        done_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;

  // Unpack the flat interval bus so the winner can index it directly.
  logic [WIDTH-1:0] ival_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign ival_arr[gi] = interval[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: first set request at or above ptr, wrapping.
  logic           found;
  logic [IDW-1:0] winner;
  int             idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Pointer value that places the current owner last in the rotation.
  logic [IDW-1:0] owner_next;
  assign owner_next = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    count_d   = count_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          busy_d          = 1'b1;
          count_d         = ival_arr[winner];
          if (ival_arr[winner] == '0) begin
            // Zero interval completes on the grant edge itself.
            done_d    = 1'b1;
            done_id_d = winner;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!req[owner_q]) begin
          // Abort wins over decrement and produces no completion.
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = owner_next;
          state_d = ST_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // Owner's req is ignored here: completion already happened.
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = owner_next;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter (NREQ=4, WIDTH=4): a table of per-cycle
// vectors for round-robin, wraparound, single-requester and zero-interval
// behaviour, then hand-written sequences for abort, async reset, and a
// maximum interval with non-owner request noise.
module tb_timer_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] interval;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  count;
  logic        done;
  logic [1:0]  done_id;

  int checks;
  int errors;

  timer_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .interval (interval),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done),
    .done_id  (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] ival;
    logic [3:0]  g;
    logic        b;
    logic [3:0]  c;
    logic        d;
    logic [1:0]  id;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [3:0] eg, input logic eb,
                       input logic [3:0] ec, input logic ed, input logic [1:0] eid);
    checks++;
    if (grant !== eg || busy !== eb || count !== ec || done !== ed || done_id !== eid) begin
      errors++;
      $display("FAIL %s: got grant=%b busy=%b count=%0d done=%b done_id=%0d, want grant=%b busy=%b count=%0d done=%b done_id=%0d",
               name, grant, busy, count, done, done_id, eg, eb, ec, ed, eid);
    end else begin
      $display("ok   %s: grant=%b busy=%b count=%0d done=%b done_id=%0d",
               name, grant, busy, count, done, done_id);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] iv);
    req      = r;
    interval = iv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    req      = 4'b0000;
    interval = 16'h0000;

    // Round robin: all requesting, all intervals 1, starting from ptr=0.
    vecs[0]  = '{4'b1111, 16'h1111, 4'b0001, 1'b1, 4'd1, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 16'h1111, 4'b0001, 1'b1, 4'd0, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 16'h1111, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};
    vecs[3]  = '{4'b1111, 16'h1111, 4'b0010, 1'b1, 4'd1, 1'b0, 2'd0};
    vecs[4]  = '{4'b1111, 16'h1111, 4'b0010, 1'b1, 4'd0, 1'b1, 2'd1};
    vecs[5]  = '{4'b1111, 16'h1111, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd1};
    vecs[6]  = '{4'b1111, 16'h1111, 4'b0100, 1'b1, 4'd1, 1'b0, 2'd1};
    vecs[7]  = '{4'b1111, 16'h1111, 4'b0100, 1'b1, 4'd0, 1'b1, 2'd2};
    vecs[8]  = '{4'b1111, 16'h1111, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd2};
    vecs[9]  = '{4'b1111, 16'h1111, 4'b1000, 1'b1, 4'd1, 1'b0, 2'd2};
    vecs[10] = '{4'b1111, 16'h1111, 4'b1000, 1'b1, 4'd0, 1'b1, 2'd3};
    vecs[11] = '{4'b1111, 16'h1111, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd3};
    vecs[12] = '{4'b1111, 16'h1111, 4'b0001, 1'b1, 4'd1, 1'b0, 2'd3};
    vecs[13] = '{4'b1111, 16'h1111, 4'b0001, 1'b1, 4'd0, 1'b1, 2'd0};
    // req dropped during DONE: completion stands; ptr becomes 1.
    vecs[14] = '{4'b0000, 16'h1111, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};
    // Single requester 0, interval 3; search from ptr=1 wraps to 0.
    vecs[15] = '{4'b0001, 16'h0003, 4'b0001, 1'b1, 4'd3, 1'b0, 2'd0};
    vecs[16] = '{4'b0001, 16'h0003, 4'b0001, 1'b1, 4'd2, 1'b0, 2'd0};
    vecs[17] = '{4'b0001, 16'h0003, 4'b0001, 1'b1, 4'd1, 1'b0, 2'd0};
    vecs[18] = '{4'b0001, 16'h0003, 4'b0001, 1'b1, 4'd0, 1'b1, 2'd0};
    vecs[19] = '{4'b0000, 16'h0003, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};
    vecs[20] = '{4'b0000, 16'h0003, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};
    // Zero interval for requester 2: done on the grant edge.
    vecs[21] = '{4'b0100, 16'h3033, 4'b0100, 1'b1, 4'd0, 1'b1, 2'd2};
    vecs[22] = '{4'b0100, 16'h3033, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd2};
    vecs[23] = '{4'b0000, 16'h3033, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd2};

    // Reset state, held across a clock edge.
    #2;
    check("reset_initial", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check("reset_held", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_idle", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].req, vecs[i].ival);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].id);
    end
    // ptr is now 3.

    // Abort: requester 1 interval 5, drop req[1] at count 3, req[2] waiting.
    step(4'b0010, 16'h0050); check("abort_grant",  4'b0010, 1'b1, 4'd5, 1'b0, 2'd2);
    step(4'b0010, 16'h0050); check("abort_cnt4",   4'b0010, 1'b1, 4'd4, 1'b0, 2'd2);
    step(4'b0010, 16'h0050); check("abort_cnt3",   4'b0010, 1'b1, 4'd3, 1'b0, 2'd2);
    step(4'b0100, 16'h0250); check("abort_drop",   4'b0000, 1'b0, 4'd0, 1'b0, 2'd2);
    step(4'b0100, 16'h0250); check("abort_next",   4'b0100, 1'b1, 4'd2, 1'b0, 2'd2);
    step(4'b0100, 16'h0250); check("abort_n_c1",   4'b0100, 1'b1, 4'd1, 1'b0, 2'd2);
    step(4'b0100, 16'h0250); check("abort_n_done", 4'b0100, 1'b1, 4'd0, 1'b1, 2'd2);
    step(4'b0000, 16'h0250); check("abort_n_rel",  4'b0000, 1'b0, 4'd0, 1'b0, 2'd2);
    // ptr is now 3.

    // Async reset mid-RUN: requester 0 interval 9, reset while count=6.
    step(4'b0001, 16'h0009); check("rst_grant", 4'b0001, 1'b1, 4'd9, 1'b0, 2'd2);
    step(4'b0001, 16'h0009); check("rst_c8",    4'b0001, 1'b1, 4'd8, 1'b0, 2'd2);
    step(4'b0001, 16'h0009); check("rst_c7",    4'b0001, 1'b1, 4'd7, 1'b0, 2'd2);
    step(4'b0001, 16'h0009); check("rst_c6",    4'b0001, 1'b1, 4'd6, 1'b0, 2'd2);
    #2;
    reset    = 1'b0;
    req      = 4'b1010;
    interval = 16'h0040;
    #1;
    check("rst_async", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check("rst_hold", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    #3;
    reset = 1'b1;
    // ptr restarted at 0, so requester 1 beats requester 3.
    step(4'b1010, 16'h0040); check("rst_regrant", 4'b0010, 1'b1, 4'd4, 1'b0, 2'd0);
    step(4'b0000, 16'h0040); check("rst_abort",   4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    // ptr is now 2.

    // Maximum interval for requester 3 while req[0] toggles.
    step(4'b1001, 16'hF001); check("max_grant", 4'b1000, 1'b1, 4'd15, 1'b0, 2'd0);
    for (int k = 14; k >= 1; k--) begin
      step((k % 2 == 0) ? 4'b1000 : 4'b1001, 16'hF001);
      check($sformatf("max_c%0d", k), 4'b1000, 1'b1, 4'(k), 1'b0, 2'd0);
    end
    step(4'b1000, 16'hF001); check("max_done", 4'b1000, 1'b1, 4'd0, 1'b1, 2'd3);
    step(4'b1001, 16'hF001); check("max_rel",  4'b0000, 1'b0, 4'd0, 1'b0, 2'd3);
    // ptr=0: requester 0 served next even though requester 3 still requests.
    step(4'b1001, 16'hF001); check("max_next",      4'b0001, 1'b1, 4'd1, 1'b0, 2'd3);
    step(4'b1001, 16'hF001); check("max_next_done", 4'b0001, 1'b1, 4'd0, 1'b1, 2'd0);
    step(4'b0000, 16'hF001); check("max_next_rel",  4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin arbiter and sequencer for one shared down-counting interval timer. Up to NREQ requesters each present a request and an interval. The block grants the timer to one requester at a time, loads that requester's interval, and counts it down once per clock. It then reports completion and moves on to the next requester. It sits between the requesting control blocks and the counter datapath, so they never drive the counter directly.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 4, width of interval and count.
- IDW, $clog2(NREQ), width of requester index (derived, not overridden).

- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; low forces reset state immediately.
- req  input  NREQ  per-requester request level; bit i = requester i.
- interval  input  NREQ*WIDTH  requester i's interval in bits [i*WIDTH +: WIDTH]; sampled only at grant.
- grant  output  NREQ  one-hot owner of the timer; all-zero when idle.
- busy  output  1  high while any grant is asserted.
- count  output  WIDTH  remaining ticks of the current interval.
- done  output  1  one-cycle completion pulse, registered.
- done_id  output  IDW  index of the requester that completed; holds last value.

## Operation
- All outputs are registered. Reset values: grant=0, busy=0, count=0, done=0, done_id=0. Internal state: round-robin pointer ptr=0, state=IDLE.
- States: IDLE, RUN, DONE.
- IDLE: if req is non-zero, the winner is the first set bit searching from ptr upward, with wraparound modulo NREQ. On the clock edge:
  - grant <= onehot(winner), busy <= 1.
  - count <= interval[winner].
  - If that interval is non-zero, go to RUN. If it is zero, go straight to DONE with done <= 1 and done_id <= winner.
- RUN, owner still requesting:
  - count > 1: count <= count-1.
  - count == 1: count <= 0, done <= 1, done_id <= owner, state <= DONE.
- RUN, owner request dropped (abort), which takes priority over decrement:
  - grant <= 0, busy <= 0, count <= 0.
  - ptr <= owner+1 mod NREQ, state <= IDLE.
  - No done pulse.
- DONE, for exactly one cycle:
  - done <= 0, grant <= 0, busy <= 0.
  - ptr <= owner+1 mod NREQ, state <= IDLE.
  - The owner's req value is ignored in this state; completion stands.
- Requests from non-owners never affect the current interval. A requester holding req high is re-served only after every other active requester has had its turn.
- Arithmetic: count is unsigned WIDTH bits and never wraps below 0. An interval of 2^WIDTH-1 is the maximum; 0 means complete immediately.
- Reset asserted mid-operation: all outputs and state return to reset values asynchronously. The in-flight interval is discarded with no done. Operation resumes in IDLE on the first clock edge after reset deasserts.

## Timing
- Grant latency: the IDLE arbitration edge E sets grant, so grant is visible one cycle after req is seen.
- Interval k ≥ 1:
  - count shows k after edge E, then k-1, ..., 0.
  - count=0 and done=1 appear after edge E+k.
  - grant drops and done clears after edge E+k+1.
- Interval 0: done=1 after edge E, and grant drops after edge E+1.
- Back-to-back service: the next grant is made at edge E+k+2 at the earliest, so the IDLE cycle between owners is always present.
- Abort detected at edge A: grant=0 after A, and a new grant is possible at A+1.
- done is exactly one cycle wide. done and the deasserting grant are never both low while the pulse belongs to the same owner.

## Test plan
- Single requester: req=0001, interval0=3, held high -> grant=0001 one cycle later; count 3,2,1,0; done=1 with done_id=0 when count=0; grant=0 the next cycle.
- Round-robin fairness: req=1111 all held, all intervals=1 -> grants occur in order 0001, 0010, 0100, 1000, 0001; done_id sequence 0,1,2,3,0; one IDLE cycle between owners.
- Zero interval: req=0100, interval2=0 -> grant=0100 and done=1 (done_id=2) in the same cycle after arbitration; count=0; grant clears next cycle.
- Abort: requester 1, interval=5; drop req[1] when count=3 -> next cycle grant=0, count=0, no done. With req[2] high, grant=0100 follows one cycle later.
- Async reset mid-RUN: interval=9, pull reset low between edges while count=6 -> all outputs are 0 immediately without a clock; after release, pending req=0010 is granted at the first edge, with ptr restarted from 0.
- Maximum interval and non-owner noise: requester 3, interval=15, while req[0] toggles every cycle -> count runs exactly 15..0 with no disturbance; done_id=3; the next grant goes to requester 0 if it is high.
